// File: rtl/load_store_buffer_if.sv
// Handshake bundle between the load/store buffer and dispatch, the LS
// reservation station, the ROB, the memory controller and the LS CDB.
interface load_store_buffer_if;
   logic        _clear;
   logic        _disp_valid;
   logic [4:0]  _disp_rob_id;
   logic        _disp_is_store;
   logic [2:0]  _disp_funct3;
   logic        _lsb_full;
   logic        _rs_ready;
   logic [4:0]  _rs_rob_id;
   logic [31:0] _rs_st_value;
   logic [31:0] _rs_ptr_value;
   logic        _rob_commit;
   logic [4:0]  _rob_commit_id;
   logic        _st_ready;
   logic [4:0]  _st_rob_id;
   logic        _mem_req;
   logic        _mem_we;
   logic [31:0] _mem_addr;
   logic [31:0] _mem_wdata;
   logic [1:0]  _mem_len;
   logic        _mem_done;
   logic [31:0] _mem_rdata;
   logic        _cdb_ls_ready;
   logic [4:0]  _cdb_ls_rob_id;
   logic [31:0] _cdb_ls_value;

   modport slave (
      input  _clear, _disp_valid, _disp_rob_id, _disp_is_store, _disp_funct3,
      input  _rs_ready, _rs_rob_id, _rs_st_value, _rs_ptr_value,
      input  _rob_commit, _rob_commit_id, _mem_done, _mem_rdata,
      output _lsb_full, _st_ready, _st_rob_id,
      output _mem_req, _mem_we, _mem_addr, _mem_wdata, _mem_len,
      output _cdb_ls_ready, _cdb_ls_rob_id, _cdb_ls_value
   );

   modport master (
      output _clear, _disp_valid, _disp_rob_id, _disp_is_store, _disp_funct3,
      output _rs_ready, _rs_rob_id, _rs_st_value, _rs_ptr_value,
      output _rob_commit, _rob_commit_id, _mem_done, _mem_rdata,
      input  _lsb_full, _st_ready, _st_rob_id,
      input  _mem_req, _mem_we, _mem_addr, _mem_wdata, _mem_len,
      input  _cdb_ls_ready, _cdb_ls_rob_id, _cdb_ls_value
   );
endinterface

// File: rtl/load_store_buffer.sv
// In-order load/store queue: one memory access at a time from the head,
// loads broadcast on the LS CDB, stores issued only once committed.
module load_store_buffer #(
   parameter int DEPTH = 8
) (
   input logic                clk_in,
   input logic                rst_in,
   input logic                rdy_in,
   load_store_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   logic        valid_q [DEPTH], valid_d [DEPTH];
   logic [4:0]  rob_id_q [DEPTH], rob_id_d [DEPTH];
   logic        is_store_q [DEPTH], is_store_d [DEPTH];
   logic [2:0]  funct3_q [DEPTH], funct3_d [DEPTH];
   logic        addr_ok_q [DEPTH], addr_ok_d [DEPTH];
   logic [31:0] addr_q [DEPTH], addr_d [DEPTH];
   logic [31:0] sdata_q [DEPTH], sdata_d [DEPTH];
   logic        committed_q [DEPTH], committed_d [DEPTH];

   logic [PW-1:0] head_q, head_d, tail_q, tail_d, idx;
   logic [CW-1:0] count_q, count_d, ncommit;
   state_e        state_q, state_d;
   logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [1:0]    mem_len_q, mem_len_d;
   logic          cdb_ready_q, cdb_ready_d;
   logic [4:0]    cdb_rob_id_q, cdb_rob_id_d;
   logic [31:0]   cdb_value_q, cdb_value_d;
   logic          st_ready_q, st_ready_d;
   logic [4:0]    st_rob_id_q, st_rob_id_d;
   logic          busy_load_q, busy_load_d, drop_q, drop_d;
   logic [2:0]    busy_f3_q, busy_f3_d;
   logic [4:0]    busy_rob_q, busy_rob_d;
   logic          full, head_ok, push, pop, run;

   function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'b000:  return {{24{d[7]}}, d[7:0]};
         3'b001:  return {{16{d[15]}}, d[15:0]};
         3'b100:  return {24'h0, d[7:0]};
         3'b101:  return {16'h0, d[15:0]};
         default: return d;
      endcase
   endfunction

   assign full = (count_q == CW'(DEPTH));
   // A load must not launch in a flush cycle; it is about to be discarded.
   assign head_ok = valid_q[head_q] && addr_ok_q[head_q] &&
                    (is_store_q[head_q] ? committed_q[head_q] : !bus._clear);

   always_comb begin
      valid_d = valid_q;  rob_id_d = rob_id_q;  is_store_d = is_store_q;
      funct3_d = funct3_q;  addr_ok_d = addr_ok_q;  addr_d = addr_q;
      sdata_d = sdata_q;  committed_d = committed_q;
      head_d = head_q;  state_d = state_q;
      mem_req_d = mem_req_q;  mem_we_d = mem_we_q;  mem_addr_d = mem_addr_q;
      mem_wdata_d = mem_wdata_q;  mem_len_d = mem_len_q;
      cdb_ready_d = 1'b0;  cdb_rob_id_d = cdb_rob_id_q;  cdb_value_d = cdb_value_q;
      st_ready_d = 1'b0;  st_rob_id_d = st_rob_id_q;
      busy_load_d = busy_load_q;  busy_f3_d = busy_f3_q;  busy_rob_d = busy_rob_q;
      drop_d = drop_q;
      push = 1'b0;  pop = 1'b0;  run = 1'b1;  ncommit = '0;  idx = head_q;

      // Committed stores form a contiguous run starting at the head.
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PW'(k);
         if (run && valid_q[idx] && committed_q[idx]) ncommit = ncommit + CW'(1);
         else run = 1'b0;
      end

      if (bus._clear) begin
         for (int i = 0; i < DEPTH; i++)
            if (!(valid_q[i] && committed_q[i])) valid_d[i] = 1'b0;
         if (state_q == BUSY && busy_load_q) drop_d = 1'b1;
      end else begin
         if (bus._disp_valid && !full) begin
            push                = 1'b1;
            valid_d[tail_q]     = 1'b1;
            rob_id_d[tail_q]    = bus._disp_rob_id;
            is_store_d[tail_q]  = bus._disp_is_store;
            funct3_d[tail_q]    = bus._disp_funct3;
            addr_ok_d[tail_q]   = 1'b0;
            committed_d[tail_q] = 1'b0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (bus._rs_ready && valid_q[i] && rob_id_q[i] == bus._rs_rob_id) begin
               addr_ok_d[i] = 1'b1;
               addr_d[i]    = bus._rs_ptr_value;
               sdata_d[i]   = bus._rs_st_value;
               if (is_store_q[i]) begin
                  st_ready_d  = 1'b1;
                  st_rob_id_d = rob_id_q[i];
               end
            end
            if (bus._rob_commit && valid_q[i] && is_store_q[i] &&
                rob_id_q[i] == bus._rob_commit_id)
               committed_d[i] = 1'b1;
         end
      end

      case (state_q)
         IDLE: if (head_ok) begin
            state_d     = BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store_q[head_q];
            mem_addr_d  = addr_q[head_q];
            mem_wdata_d = sdata_q[head_q];
            mem_len_d   = funct3_q[head_q][1:0];
            busy_load_d = !is_store_q[head_q];
            busy_f3_d   = funct3_q[head_q];
            busy_rob_d  = rob_id_q[head_q];
            drop_d      = 1'b0;
         end
         BUSY: if (bus._mem_done) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            drop_d    = 1'b0;
            // A flushed load's entry is already gone; nothing to pop or broadcast.
            if (!(busy_load_q && (drop_q || bus._clear))) begin
               pop            = 1'b1;
               valid_d[head_q] = 1'b0;
               head_d         = head_q + PW'(1);
               if (busy_load_q) begin
                  cdb_ready_d  = 1'b1;
                  cdb_rob_id_d = busy_rob_q;
                  cdb_value_d  = ext_load(busy_f3_q, bus._mem_rdata);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      tail_d  = bus._clear ? head_q + ncommit[PW-1:0] : tail_q + PW'(push);
      count_d = (bus._clear ? ncommit : count_q + CW'(push)) - CW'(pop);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_q <= '{default: 1'b0};
         head_q <= '0;  tail_q <= '0;  count_q <= '0;  state_q <= IDLE;
         mem_req_q <= 1'b0;  mem_we_q <= 1'b0;  mem_addr_q <= '0;
         mem_wdata_q <= '0;  mem_len_q <= '0;
         cdb_ready_q <= 1'b0;  cdb_rob_id_q <= '0;  cdb_value_q <= '0;
         st_ready_q <= 1'b0;  st_rob_id_q <= '0;
         busy_load_q <= 1'b0;  busy_f3_q <= '0;  busy_rob_q <= '0;  drop_q <= 1'b0;
      end else if (rdy_in) begin
         valid_q <= valid_d;
         head_q <= head_d;  tail_q <= tail_d;  count_q <= count_d;  state_q <= state_d;
         mem_req_q <= mem_req_d;  mem_we_q <= mem_we_d;  mem_addr_q <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;  mem_len_q <= mem_len_d;
         cdb_ready_q <= cdb_ready_d;  cdb_rob_id_q <= cdb_rob_id_d;  cdb_value_q <= cdb_value_d;
         st_ready_q <= st_ready_d;  st_rob_id_q <= st_rob_id_d;
         busy_load_q <= busy_load_d;  busy_f3_q <= busy_f3_d;  busy_rob_q <= busy_rob_d;
         drop_q <= drop_d;
      end
   end

   // Entry payload is qualified by valid_q, so it needs no reset.
   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         rob_id_q <= rob_id_d;  is_store_q <= is_store_d;  funct3_q <= funct3_d;
         addr_ok_q <= addr_ok_d;  addr_q <= addr_d;  sdata_q <= sdata_d;
         committed_q <= committed_d;
      end
   end

   assign bus._lsb_full      = full;
   assign bus._st_ready      = st_ready_q;
   assign bus._st_rob_id     = st_rob_id_q;
   assign bus._mem_req       = mem_req_q;
   assign bus._mem_we        = mem_we_q;
   assign bus._mem_addr      = mem_addr_q;
   assign bus._mem_wdata     = mem_wdata_q;
   assign bus._mem_len       = mem_len_q;
   assign bus._cdb_ls_ready  = cdb_ready_q;
   assign bus._cdb_ls_rob_id = cdb_rob_id_q;
   assign bus._cdb_ls_value  = cdb_value_q;
endmodule

// File: tb/tb_load_store_buffer.sv
// Directed bench for load_store_buffer: loads, stores, ordering, flush,
// full/wrap, stall and reset scenarios with hand-computed expectations.
module tb_load_store_buffer;
   logic clk_in = 1'b0;
   logic rst_in, rdy_in;
   int   n_cmp = 0;
   int   n_bad = 0;

   load_store_buffer_if bus ();
   load_store_buffer #(.DEPTH(8)) dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus));

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_in();
      bus._clear = 0; bus._disp_valid = 0; bus._disp_rob_id = 0; bus._disp_is_store = 0;
      bus._disp_funct3 = 0; bus._rs_ready = 0; bus._rs_rob_id = 0; bus._rs_st_value = 0;
      bus._rs_ptr_value = 0; bus._rob_commit = 0; bus._rob_commit_id = 0;
      bus._mem_done = 0; bus._mem_rdata = 0;
   endtask

   task automatic dispatch(input logic [4:0] id, input logic st, input logic [2:0] f3);
      bus._disp_valid = 1; bus._disp_rob_id = id; bus._disp_is_store = st; bus._disp_funct3 = f3;
      tick();
      bus._disp_valid = 0;
   endtask

   task automatic deliver(input logic [4:0] id, input logic [31:0] addr, input logic [31:0] data);
      bus._rs_ready = 1; bus._rs_rob_id = id; bus._rs_ptr_value = addr; bus._rs_st_value = data;
      tick();
      bus._rs_ready = 0;
   endtask

   task automatic commit(input logic [4:0] id);
      bus._rob_commit = 1; bus._rob_commit_id = id;
      tick();
      bus._rob_commit = 0;
   endtask

   task automatic mem_finish(input logic [31:0] rdata);
      bus._mem_done = 1; bus._mem_rdata = rdata;
      tick();
      bus._mem_done = 0;
   endtask

   // Head load already dispatched: deliver address, expect request, complete it.
   task automatic exec_load(input logic [4:0] id, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
      deliver(id, addr, 32'h0);
      chk("ld_no_req_yet", bus._mem_req, 0);
      tick();
      chk("ld_req", bus._mem_req, 1);
      chk("ld_we", bus._mem_we, 0);
      chk("ld_addr", bus._mem_addr, addr);
      chk("ld_len", bus._mem_len, {30'h0, f3[1:0]});
      mem_finish(rdata);
      chk("ld_cdb_rdy", bus._cdb_ls_ready, 1);
      chk("ld_cdb_id", bus._cdb_ls_rob_id, id);
      chk("ld_cdb_val", bus._cdb_ls_value, exp);
      chk("ld_req_drop", bus._mem_req, 0);
   endtask

   initial begin
      idle_in();
      rst_in = 1; rdy_in = 1;
      tick(); tick();
      rst_in = 0;
      chk("rst_full", bus._lsb_full, 0);
      chk("rst_st_ready", bus._st_ready, 0);
      chk("rst_mem_req", bus._mem_req, 0);
      chk("rst_mem_we", bus._mem_we, 0);
      chk("rst_cdb", bus._cdb_ls_ready, 0);
      chk("rst_addr", bus._mem_addr, 0);
      chk("rst_cdb_val", bus._cdb_ls_value, 0);
      chk("rst_count", 32'(dut.count_q), 0);

      // Load extensions
      dispatch(3, 0, 3'b000); exec_load(3, 3'b000, 32'h100, 32'h0000_00F0, 32'hFFFF_FFF0);
      tick();
      chk("cdb_one_cycle", bus._cdb_ls_ready, 0);
      dispatch(4, 0, 3'b100); exec_load(4, 3'b100, 32'h100, 32'h0000_00F0, 32'h0000_00F0);
      dispatch(6, 0, 3'b001); exec_load(6, 3'b001, 32'h102, 32'h1234_8001, 32'hFFFF_8001);
      dispatch(7, 0, 3'b010); exec_load(7, 3'b010, 32'h104, 32'h89AB_CDEF, 32'h89AB_CDEF);
      dispatch(10, 0, 3'b101); exec_load(10, 3'b101, 32'h106, 32'hFFFF_9001, 32'h0000_9001);

      // Store waits for commit
      dispatch(5, 1, 3'b010);
      deliver(5, 32'h200, 32'hDEAD_BEEF);
      chk("st_ready", bus._st_ready, 1);
      chk("st_rob_id", bus._st_rob_id, 5);
      tick();
      chk("st_ready_pulse", bus._st_ready, 0);
      tick(); tick();
      chk("st_no_req_uncommitted", bus._mem_req, 0);
      commit(5);
      chk("st_req_after_commit_edge", bus._mem_req, 0);
      tick();
      chk("st_req", bus._mem_req, 1);
      chk("st_we", bus._mem_we, 1);
      chk("st_addr", bus._mem_addr, 32'h200);
      chk("st_wdata", bus._mem_wdata, 32'hDEAD_BEEF);
      chk("st_len", bus._mem_len, 2);
      mem_finish(32'h0);
      chk("st_no_cdb", bus._cdb_ls_ready, 0);
      chk("st_req_drop", bus._mem_req, 0);

      // Fill, wrap, dispatch+pop at count 7
      for (int i = 0; i < 8; i++) begin
         chk("not_full_yet", bus._lsb_full, 0);
         dispatch(5'(8 + i), 0, 3'b010);
      end
      chk("full", bus._lsb_full, 1);
      dispatch(20, 0, 3'b010);
      chk("full_disp_ignored", 32'(dut.count_q), 8);
      exec_load(8, 3'b010, 32'h300, 32'h11, 32'h11);
      chk("full_clears", bus._lsb_full, 0);
      deliver(9, 32'h304, 32'h0);
      tick();
      chk("c7_req", bus._mem_req, 1);
      bus._mem_done = 1; bus._mem_rdata = 32'h22;
      bus._disp_valid = 1; bus._disp_rob_id = 21; bus._disp_is_store = 0; bus._disp_funct3 = 3'b010;
      tick();
      idle_in();
      chk("c7_cdb_id", bus._cdb_ls_rob_id, 9);
      chk("c7_count", 32'(dut.count_q), 7);
      chk("c7_full", bus._lsb_full, 0);
      for (int i = 10; i < 16; i++) exec_load(5'(i), 3'b010, 32'h400 + 32'(i), 32'(i), 32'(i));
      exec_load(21, 3'b010, 32'h480, 32'h5A5A_5A5A, 32'h5A5A_5A5A);
      chk("drain_count", 32'(dut.count_q), 0);

      // Older uncommitted store blocks younger ready load
      dispatch(1, 1, 3'b010);
      dispatch(2, 0, 3'b010);
      deliver(2, 32'h500, 32'h0);
      chk("ord_ld_no_st_ready", bus._st_ready, 0);
      deliver(1, 32'h504, 32'h0000_CAFE);
      chk("ord_st_ready_id", bus._st_rob_id, 1);
      tick(); tick();
      chk("ord_load_waits", bus._mem_req, 0);
      commit(1);
      tick();
      chk("ord_first_req_we", bus._mem_we, 1);
      chk("ord_first_addr", bus._mem_addr, 32'h504);
      mem_finish(32'h0);
      chk("ord_gap", bus._mem_req, 0);
      tick();
      chk("ord_second_req", bus._mem_req, 1);
      chk("ord_second_we", bus._mem_we, 0);
      chk("ord_second_addr", bus._mem_addr, 32'h500);
      mem_finish(32'h77);
      chk("ord_cdb_id", bus._cdb_ls_rob_id, 2);
      chk("ord_cdb_val", bus._cdb_ls_value, 32'h77);

      // Flush with committed store in BUSY
      dispatch(1, 1, 3'b000);
      bus._disp_valid = 1; bus._disp_rob_id = 2; bus._disp_is_store = 0; bus._disp_funct3 = 3'b010;
      bus._rs_ready = 1; bus._rs_rob_id = 1; bus._rs_ptr_value = 32'h600; bus._rs_st_value = 32'hAB;
      tick();
      idle_in();
      chk("fl_st_ready", bus._st_ready, 1);
      bus._rob_commit = 1; bus._rob_commit_id = 1;
      bus._rs_ready = 1; bus._rs_rob_id = 2; bus._rs_ptr_value = 32'h604;
      tick();
      idle_in();
      tick();
      chk("fl_st_req", bus._mem_req, 1);
      chk("fl_st_addr", bus._mem_addr, 32'h600);
      chk("fl_st_len", bus._mem_len, 0);
      bus._clear = 1;
      tick();
      bus._clear = 0;
      chk("fl_kept_count", 32'(dut.count_q), 1);
      mem_finish(32'h0);
      chk("fl_st_done_req", bus._mem_req, 0);
      tick();
      chk("fl_load_gone", bus._mem_req, 0);
      chk("fl_count0", 32'(dut.count_q), 0);

      // Flush with load in BUSY: no CDB pulse
      dispatch(7, 0, 3'b010);
      deliver(7, 32'h700, 32'h0);
      tick();
      chk("fl_ld_req", bus._mem_req, 1);
      bus._clear = 1;
      tick();
      bus._clear = 0;
      chk("fl_ld_req_held", bus._mem_req, 1);
      mem_finish(32'h5);
      chk("fl_ld_no_cdb", bus._cdb_ls_ready, 0);
      chk("fl_ld_req_drop", bus._mem_req, 0);
      chk("fl_ld_count", 32'(dut.count_q), 0);
      dispatch(3, 0, 3'b000); exec_load(3, 3'b000, 32'h710, 32'h0000_0080, 32'hFFFF_FF80);

      // Stall during BUSY
      dispatch(4, 0, 3'b001);
      deliver(4, 32'h800, 32'h0);
      tick();
      chk("stall_req", bus._mem_req, 1);
      rdy_in = 0;
      bus._disp_valid = 1; bus._disp_rob_id = 9; bus._disp_is_store = 0; bus._disp_funct3 = 3'b010;
      tick(); tick(); tick();
      chk("stall_req_held", bus._mem_req, 1);
      chk("stall_addr_held", bus._mem_addr, 32'h800);
      chk("stall_count_held", 32'(dut.count_q), 1);
      idle_in();
      rdy_in = 1;
      mem_finish(32'h0000_8000);
      chk("stall_cdb_id", bus._cdb_ls_rob_id, 4);
      chk("stall_cdb_val", bus._cdb_ls_value, 32'hFFFF_8000);

      // Reset mid-transaction
      dispatch(12, 0, 3'b010);
      deliver(12, 32'h900, 32'h0);
      tick();
      chk("rstm_req", bus._mem_req, 1);
      rst_in = 1;
      tick();
      rst_in = 0;
      chk("rstm_req_drop", bus._mem_req, 0);
      chk("rstm_count", 32'(dut.count_q), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
